// File: rtl/block_pingpong_buffer_pkg.sv
// Shared encodings and sizes for the double-buffered coefficient block store.
package block_pingpong_buffer_pkg;

  localparam int unsigned COEFF_WIDTH  = 12;
  localparam int unsigned INDEX_WIDTH  = 6;
  localparam int unsigned BLOCK_COEFFS = 64;
  localparam int unsigned BANK_COUNT   = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_STREAM   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/block_buffer_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module block_buffer_ram #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its word when rd_en is low, which gives output stall for free.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/block_pingpong_buffer.sv
// Two-bank coefficient store between the dequantiser and the IDCT: one bank fills while the other streams out in raster order.
module block_pingpong_buffer
  import block_pingpong_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = COEFF_WIDTH,
  parameter int unsigned ADDR_WIDTH = INDEX_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  Wr_Block_Start_I,
  input  logic                  Wr_Block_Done_I,
  output logic                  Wr_Ready_O,
  input  logic                  Wr_En_I,
  input  logic [ADDR_WIDTH-1:0] Wr_Address_I,
  input  logic [DATA_WIDTH-1:0] Wr_Data_I,
  output logic                  Rd_Valid_O,
  input  logic                  Rd_Ready_I,
  output logic [DATA_WIDTH-1:0] Rd_Data_O,
  output logic [ADDR_WIDTH-1:0] Rd_Index_O,
  output logic                  Rd_Last_O,
  output logic                  Protocol_Error_O
);

  localparam int unsigned RAM_ADDR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  bank_state_t bank_q [BANK_COUNT];
  bank_state_t bank_d [BANK_COUNT];
  logic        wr_sel_q;
  logic        wr_sel_d;
  logic        rd_sel_q;
  logic        rd_sel_d;
  rd_state_t   rd_state_q;
  rd_state_t   rd_state_d;

  logic [ADDR_WIDTH-1:0] rd_index_q;
  logic [ADDR_WIDTH-1:0] rd_index_d;
  logic [ADDR_WIDTH-1:0] rd_index_inc_c;
  logic                  rd_valid_q;
  logic                  rd_valid_d;
  logic                  rd_last_q;
  logic                  rd_last_d;
  logic                  error_q;
  logic                  error_d;

  logic                      wr_accept_c;
  logic                      rd_accept_c;
  logic                      ram_rd_en_c;
  logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr_c;
  logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr_c;
  logic [DATA_WIDTH-1:0]     ram_rd_data;

  assign wr_accept_c    = Wr_En_I && (bank_q[wr_sel_q] == BANK_FILLING);
  assign rd_accept_c    = rd_valid_q && Rd_Ready_I;
  assign rd_index_inc_c = rd_index_q + ADDR_WIDTH'(1);
  assign ram_wr_addr_c  = {wr_sel_q, Wr_Address_I};

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bank_q[0]  <= BANK_EMPTY;
      bank_q[1]  <= BANK_EMPTY;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_index_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      rd_state_q <= rd_state_d;
      rd_index_q <= rd_index_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      error_q    <= error_d;
    end
  end

  // Next-state: write-side bank handshake and read FSM. The write side only
  // moves banks out of EMPTY/FILLING and the read side only out of FULL/DRAINING,
  // so the two never update the same bank entry in one cycle.
  always_comb begin
    bank_d        = bank_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    rd_state_d    = rd_state_q;
    rd_index_d    = rd_index_q;
    rd_valid_d    = rd_valid_q;
    rd_last_d     = rd_last_q;
    error_d       = error_q;
    ram_rd_en_c   = 1'b0;
    ram_rd_addr_c = {rd_sel_q, rd_index_q};

    if (Wr_En_I && (bank_q[wr_sel_q] != BANK_FILLING)) begin
      error_d = 1'b1;
    end

    // Done wins over a simultaneous Start; the producer must retry Start.
    if (Wr_Block_Done_I) begin
      if (bank_q[wr_sel_q] == BANK_FILLING) begin
        bank_d[wr_sel_q] = BANK_FULL;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        error_d = 1'b1;
      end
      if (Wr_Block_Start_I) begin
        error_d = 1'b1;
      end
    end else if (Wr_Block_Start_I) begin
      if (bank_q[wr_sel_q] == BANK_EMPTY) begin
        bank_d[wr_sel_q] = BANK_FILLING;
      end else begin
        error_d = 1'b1;
      end
    end

    unique case (rd_state_q)
      RD_IDLE: begin
        if (bank_q[rd_sel_q] == BANK_FULL) begin
          bank_d[rd_sel_q] = BANK_DRAINING;
          rd_index_d       = '0;
          rd_last_d        = 1'b0;
          rd_state_d       = RD_PREFETCH;
        end
      end
      RD_PREFETCH: begin
        ram_rd_en_c = 1'b1;
        rd_valid_d  = 1'b1;
        rd_state_d  = RD_STREAM;
      end
      RD_STREAM: begin
        if (rd_accept_c) begin
          if (rd_last_q) begin
            bank_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d         = ~rd_sel_q;
            rd_valid_d       = 1'b0;
            rd_last_d        = 1'b0;
            rd_state_d       = RD_IDLE;
          end else begin
            ram_rd_en_c   = 1'b1;
            ram_rd_addr_c = {rd_sel_q, rd_index_inc_c};
            rd_index_d    = rd_index_inc_c;
            rd_last_d     = (rd_index_inc_c == LAST_INDEX);
          end
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  block_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_accept_c),
    .wr_addr (ram_wr_addr_c),
    .wr_data (Wr_Data_I),
    .rd_en   (ram_rd_en_c),
    .rd_addr (ram_rd_addr_c),
    .rd_data (ram_rd_data)
  );

  assign Wr_Ready_O       = (bank_q[wr_sel_q] == BANK_EMPTY);
  assign Rd_Valid_O       = rd_valid_q;
  assign Rd_Data_O        = ram_rd_data;
  assign Rd_Index_O       = rd_index_q;
  assign Rd_Last_O        = rd_last_q;
  assign Protocol_Error_O = error_q;

endmodule

// File: tb/tb_block_pingpong_buffer.sv
// Directed self-checking bench for block_pingpong_buffer with an in-order expected-word queue.
module tb_block_pingpong_buffer;

  logic        clock;
  logic        resetn;
  logic        Wr_Block_Start_I;
  logic        Wr_Block_Done_I;
  logic        Wr_Ready_O;
  logic        Wr_En_I;
  logic [5:0]  Wr_Address_I;
  logic [11:0] Wr_Data_I;
  logic        Rd_Valid_O;
  logic        Rd_Ready_I;
  logic [11:0] Rd_Data_O;
  logic [5:0]  Rd_Index_O;
  logic        Rd_Last_O;
  logic        Protocol_Error_O;

  int          n_checks;
  int          n_errors;
  logic [17:0] exp_q [$];
  logic [17:0] mon_w;
  bit          rand_ready;

  block_pingpong_buffer dut (
    .clock            (clock),
    .resetn           (resetn),
    .Wr_Block_Start_I (Wr_Block_Start_I),
    .Wr_Block_Done_I  (Wr_Block_Done_I),
    .Wr_Ready_O       (Wr_Ready_O),
    .Wr_En_I          (Wr_En_I),
    .Wr_Address_I     (Wr_Address_I),
    .Wr_Data_I        (Wr_Data_I),
    .Rd_Valid_O       (Rd_Valid_O),
    .Rd_Ready_I       (Rd_Ready_I),
    .Rd_Data_O        (Rd_Data_O),
    .Rd_Index_O       (Rd_Index_O),
    .Rd_Last_O        (Rd_Last_O),
    .Protocol_Error_O (Protocol_Error_O)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; optionally reshuffle ready.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (rand_ready) Rd_Ready_I = ($urandom_range(0, 2) == 0);
  endtask

  task automatic exp_push(input logic [5:0] idx, input logic [11:0] data);
    exp_q.push_back({idx, data});
  endtask

  // Writes a whole block in a scrambled scan order; data = base + raster address.
  task automatic fill_words(input logic [11:0] base);
    for (int k = 0; k < 64; k++) begin
      logic [5:0] a;
      a = 6'(k * 37);
      Wr_En_I      = 1'b1;
      Wr_Address_I = a;
      Wr_Data_I    = base + 12'(a);
      cyc();
    end
    Wr_En_I = 1'b0;
    for (int k = 0; k < 64; k++) exp_push(6'(k), base + 12'(k));
  endtask

  task automatic fill_block(input logic [11:0] base);
    Wr_Block_Start_I = 1'b1;
    cyc();
    Wr_Block_Start_I = 1'b0;
    fill_words(base);
    Wr_Block_Done_I = 1'b1;
    cyc();
    Wr_Block_Done_I = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check({tag, " words left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    resetn           = 1'b0;
    Wr_Block_Start_I = 1'b0;
    Wr_Block_Done_I  = 1'b0;
    Wr_En_I          = 1'b0;
    Wr_Address_I     = '0;
    Wr_Data_I        = '0;
    Rd_Ready_I       = 1'b0;
    rand_ready       = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  // Scoreboard: every accepted word must match the head of the expected queue.
  always @(negedge clock) begin
    if (resetn && Rd_Valid_O && Rd_Ready_I) begin
      if (exp_q.size() == 0) begin
        check("spurious word index", 32'(Rd_Index_O), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("rd_index", 32'(Rd_Index_O), 32'(mon_w[17:12]));
        check("rd_data", 32'(Rd_Data_O), 32'(mon_w[11:0]));
        check("rd_last", 32'(Rd_Last_O), 32'(mon_w[17:12] == 6'd63));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int seen;
    n_checks = 0;
    n_errors = 0;
    reset_dut();

    check("reset wr_ready", 32'(Wr_Ready_O), 32'd1);
    check("reset rd_valid", 32'(Rd_Valid_O), 32'd0);
    check("reset rd_data", 32'(Rd_Data_O), 32'd0);
    check("reset rd_index", 32'(Rd_Index_O), 32'd0);
    check("reset rd_last", 32'(Rd_Last_O), 32'd0);
    check("reset error", 32'(Protocol_Error_O), 32'd0);

    // 1: single block, data = index - 32, read latency from Done
    Rd_Ready_I = 1'b1;
    fill_block(12'hFE0);
    check("t1 valid at done edge", 32'(Rd_Valid_O), 32'd0);
    cyc();
    check("t1 valid one after done", 32'(Rd_Valid_O), 32'd0);
    cyc();
    check("t1 valid two after done", 32'(Rd_Valid_O), 32'd1);
    check("t1 first index", 32'(Rd_Index_O), 32'd0);
    wait_drain("t1");
    check("t1 valid after last", 32'(Rd_Valid_O), 32'd0);
    check("t1 wr_ready after last", 32'(Wr_Ready_O), 32'd1);
    check("t1 error", 32'(Protocol_Error_O), 32'd0);

    // 2: overlap, B filled while A drains under random ready
    rand_ready = 1'b1;
    fill_block(12'h100);
    fill_block(12'h200);
    check("t2 wr_ready both busy", 32'(Wr_Ready_O), 32'd0);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() <= 64) break;
      cyc();
    end
    check("t2 wr_ready after A drained", 32'(Wr_Ready_O), 32'd1);
    wait_drain("t2");
    rand_ready = 1'b0;
    check("t2 error", 32'(Protocol_Error_O), 32'd0);

    // 3: backpressure for 5 cycles at index 17
    Rd_Ready_I = 1'b1;
    fill_block(12'h300);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (Rd_Valid_O && Rd_Index_O == 6'd17) begin
        hit = 1'b1;
        break;
      end
    end
    Rd_Ready_I = 1'b0;
    check("t3 reached index 17", 32'(hit), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t3 held index", 32'(Rd_Index_O), 32'd17);
      check("t3 held data", 32'(Rd_Data_O), 32'h311);
      check("t3 held valid", 32'(Rd_Valid_O), 32'd1);
    end
    Rd_Ready_I = 1'b1;
    cyc();
    check("t3 resumed index", 32'(Rd_Index_O), 32'd18);
    wait_drain("t3");

    // 4a: write with no open bank
    reset_dut();
    Wr_En_I = 1'b1; Wr_Address_I = 6'd3; Wr_Data_I = 12'hABC;
    cyc();
    Wr_En_I = 1'b0;
    check("t4a error", 32'(Protocol_Error_O), 32'd1);
    check("t4a wr_ready", 32'(Wr_Ready_O), 32'd1);

    // 4b: Start and Done together; Done applies, Start is dropped
    reset_dut();
    Rd_Ready_I = 1'b1;
    Wr_Block_Start_I = 1'b1;
    cyc();
    Wr_Block_Start_I = 1'b0;
    fill_words(12'h500);
    check("t4b error before", 32'(Protocol_Error_O), 32'd0);
    Wr_Block_Start_I = 1'b1; Wr_Block_Done_I = 1'b1;
    cyc();
    Wr_Block_Start_I = 1'b0; Wr_Block_Done_I = 1'b0;
    check("t4b error", 32'(Protocol_Error_O), 32'd1);
    check("t4b next bank still empty", 32'(Wr_Ready_O), 32'd1);
    wait_drain("t4b");

    // 4c: third Start plus a stray write while both banks are occupied
    reset_dut();
    fill_block(12'h600);
    fill_block(12'h680);
    check("t4c wr_ready both full", 32'(Wr_Ready_O), 32'd0);
    check("t4c error before", 32'(Protocol_Error_O), 32'd0);
    Wr_Block_Start_I = 1'b1; Wr_En_I = 1'b1; Wr_Address_I = 6'd0; Wr_Data_I = 12'hBAD;
    cyc();
    Wr_Block_Start_I = 1'b0; Wr_En_I = 1'b0;
    check("t4c error", 32'(Protocol_Error_O), 32'd1);
    check("t4c wr_ready unchanged", 32'(Wr_Ready_O), 32'd0);
    Rd_Ready_I = 1'b1;
    wait_drain("t4c");

    // 5: duplicate write to addr 5, and addr 63 written alongside Done
    reset_dut();
    Rd_Ready_I = 1'b1;
    Wr_Block_Start_I = 1'b1;
    cyc();
    Wr_Block_Start_I = 1'b0;
    for (int k = 0; k < 63; k++) begin
      Wr_En_I = 1'b1; Wr_Address_I = 6'(k);
      Wr_Data_I = (k == 5) ? 12'h7FF : 12'h400 + 12'(k);
      cyc();
    end
    Wr_Address_I = 6'd5; Wr_Data_I = 12'h800;
    cyc();
    Wr_Address_I = 6'd63; Wr_Data_I = 12'h5A5; Wr_Block_Done_I = 1'b1;
    cyc();
    Wr_En_I = 1'b0; Wr_Block_Done_I = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_push(6'(k), (k == 5) ? 12'h800 : (k == 63) ? 12'h5A5 : 12'h400 + 12'(k));
    end
    wait_drain("t5");
    check("t5 error", 32'(Protocol_Error_O), 32'd0);

    // 6: reset mid-drain at index 30 with the other bank full
    reset_dut();
    fill_block(12'h700);
    fill_block(12'h780);
    Rd_Ready_I = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (Rd_Valid_O && Rd_Index_O == 6'd30) begin
        hit = 1'b1;
        break;
      end
    end
    check("t6 reached index 30", 32'(hit), 32'd1);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("t6 reset rd_valid", 32'(Rd_Valid_O), 32'd0);
    check("t6 reset rd_data", 32'(Rd_Data_O), 32'd0);
    check("t6 reset rd_index", 32'(Rd_Index_O), 32'd0);
    check("t6 reset rd_last", 32'(Rd_Last_O), 32'd0);
    check("t6 reset wr_ready", 32'(Wr_Ready_O), 32'd1);
    cyc();
    check("t6 next cycle rd_valid", 32'(Rd_Valid_O), 32'd0);
    check("t6 next cycle error", 32'(Protocol_Error_O), 32'd0);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (Rd_Valid_O) seen++;
    end
    check("t6 stale valid cycles", 32'(seen), 32'd0);
    check("t6 wr_ready after reset", 32'(Wr_Ready_O), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
